mem_port_arbiter: RTL

Two-to-one arbiter sharing a single external memory port between the hart's instruction fetch port (prefetch unit side) and data port (load/store queue side). It forwards one request per cycle under a data-priority policy with an instruction anti-starvation limit. It records the owner of every accepted request in an in-order ID FIFO so responses return to the correct requester. It sits between the core top level and a unified memory or cache interconnect and adds no latency on either the request or the response path.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/arb_id_fifo.sv | 73 +++++++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, bus IDs and payload types for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned HPL_W    = 2;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned STREAK_W = 4;

  // Requester IDs stored in the ID FIFO.
  localparam logic RV_BUSID_INSTR = 1'b0;
  localparam logic RV_BUSID_DATA  = 1'b1;

  // Size code used for every instruction fetch.
  localparam logic [SIZE_W-1:0] RV_BUSSIZE_WORD = 2'b10;

  // Memory request payload.
  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic              dvalid;
    logic [HPL_W-1:0]  hpl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mreq_t;

  // Saturating increment for the data streak counter.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] v);
    return (v == '1) ? v : v + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory requests.
module arb_id_fifo #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned DEPTH_X = 2
) (
  input  logic               clk_i,
  input  logic               resetb_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   head_o,
  output logic [DEPTH_X:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_X;
  localparam int unsigned CNT_W = DEPTH_X + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [DEPTH_X-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_X-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Overflow/underflow are ignored rather than corrupting state.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer, count and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + DEPTH_X'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + DEPTH_X'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-to-one instruction/data arbiter onto one memory port with in-order response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned C_OUTST_X     = 2,
  parameter int unsigned C_MAX_DSTREAK = 3
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  // instruction request
  output logic              ireqready_o,
  input  logic              ireqvalid_i,
  input  logic [HPL_W-1:0]  ireqhpl_i,
  input  logic [ADDR_W-1:0] ireqaddr_i,
  // instruction response
  input  logic              irspready_i,
  output logic              irspvalid_o,
  output logic              irsprerr_o,
  output logic [DATA_W-1:0] irspdata_o,
  // data request
  output logic              dreqready_o,
  input  logic              dreqvalid_i,
  input  logic [SIZE_W-1:0] dreqsize_i,
  input  logic              dreqdvalid_i,
  input  logic [HPL_W-1:0]  dreqhpl_i,
  input  logic [ADDR_W-1:0] dreqaddr_i,
  input  logic [DATA_W-1:0] dreqdata_i,
  // data response
  input  logic              drspready_i,
  output logic              drspvalid_o,
  output logic              drsprerr_o,
  output logic              drspwerr_o,
  output logic [DATA_W-1:0] drspdata_o,
  // memory request
  input  logic              mreqready_i,
  output logic              mreqvalid_o,
  output logic [SIZE_W-1:0] mreqsize_o,
  output logic              mreqdvalid_o,
  output logic [HPL_W-1:0]  mreqhpl_o,
  output logic [ADDR_W-1:0] mreqaddr_o,
  output logic [DATA_W-1:0] mreqdata_o,
  // memory response
  output logic              mrspready_o,
  input  logic              mrspvalid_i,
  input  logic              mrsprerr_i,
  input  logic              mrspwerr_i,
  input  logic [DATA_W-1:0] mrspdata_i
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(C_MAX_DSTREAK);

  logic                lock_q, lock_d;
  logic                owner_q, owner_d;
  logic [STREAK_W-1:0] dstreak_q, dstreak_d;

  logic                gnt_any, gnt_id, gnt_valid, req_ok;
  logic                mreq_hs, i_hs, d_hs, mrsp_hs;
  mreq_t               mreq;

  logic                fifo_head, fifo_full, fifo_empty;
  logic [C_OUTST_X:0]  fifo_count;
  logic                unused_fifo_count;

  assign unused_fifo_count = ^fifo_count;

  assign mreq_hs = mreqvalid_o & mreqready_i;
  assign i_hs    = ireqvalid_i & ireqready_o;
  assign d_hs    = dreqvalid_i & dreqready_o;
  assign mrsp_hs = mrspvalid_i & mrspready_o;

  assign mreqsize_o   = mreq.size;
  assign mreqdvalid_o = mreq.dvalid;
  assign mreqhpl_o    = mreq.hpl;
  assign mreqaddr_o   = mreq.addr;
  assign mreqdata_o   = mreq.data;

  // Owner of each accepted request, consumed in order by responses.
  arb_id_fifo #(
    .WIDTH   (1),
    .DEPTH_X (C_OUTST_X)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .push_i   (mreq_hs),
    .data_i   (gnt_id),
    .pop_i    (mrsp_hs),
    .head_o   (fifo_head),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Lock, owner and streak registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      lock_q    <= 1'b0;
      owner_q   <= RV_BUSID_INSTR;
      dstreak_q <= '0;
    end else begin
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      dstreak_q <= dstreak_d;
    end
  end

  // Next-state: hold grant across a stalled request, track data streak.
  always_comb begin
    lock_d    = lock_q;
    owner_d   = owner_q;
    dstreak_d = dstreak_q;
    if (clk_en_i) begin
      if (mreqvalid_o && !mreqready_i) begin
        lock_d  = 1'b1;
        owner_d = gnt_id;
      end else if (mreq_hs) begin
        lock_d  = 1'b0;
      end
      if (i_hs) begin
        dstreak_d = '0;
      end else if (d_hs) begin
        dstreak_d = ireqvalid_i ? streak_inc(dstreak_q) : '0;
      end
    end
  end

  // Outputs: grant selection, request mux and response routing.
  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = RV_BUSID_INSTR;
    gnt_valid   = 1'b0;
    mreq        = '0;
    mreqvalid_o = 1'b0;
    ireqready_o = 1'b0;
    dreqready_o = 1'b0;
    irspvalid_o = 1'b0;
    irsprerr_o  = 1'b0;
    irspdata_o  = '0;
    drspvalid_o = 1'b0;
    drsprerr_o  = 1'b0;
    drspwerr_o  = 1'b0;
    drspdata_o  = '0;
    mrspready_o = 1'b0;

    req_ok = clk_en_i & ~fifo_full;

    if (lock_q) begin
      gnt_any = 1'b1;
      gnt_id  = owner_q;
    end else if (dreqvalid_i && !((dstreak_q == MAX_STREAK) && ireqvalid_i)) begin
      gnt_any = 1'b1;
      gnt_id  = RV_BUSID_DATA;
    end else if (ireqvalid_i) begin
      gnt_any = 1'b1;
      gnt_id  = RV_BUSID_INSTR;
    end

    if (gnt_any) begin
      if (gnt_id == RV_BUSID_DATA) begin
        gnt_valid   = dreqvalid_i;
        dreqready_o = mreqready_i & req_ok;
        mreq.size   = dreqsize_i;
        mreq.dvalid = dreqdvalid_i;
        mreq.hpl    = dreqhpl_i;
        mreq.addr   = dreqaddr_i;
        mreq.data   = dreqdata_i;
      end else begin
        gnt_valid   = ireqvalid_i;
        ireqready_o = mreqready_i & req_ok;
        mreq.size   = RV_BUSSIZE_WORD;
        mreq.dvalid = 1'b0;
        mreq.hpl    = ireqhpl_i;
        mreq.addr   = ireqaddr_i;
        mreq.data   = '0;
      end
    end
    mreqvalid_o = gnt_valid & req_ok;

    // With no outstanding ID a response is stalled, never delivered.
    if (!fifo_empty) begin
      if (fifo_head == RV_BUSID_INSTR) begin
        irspvalid_o = mrspvalid_i & clk_en_i;
        mrspready_o = irspready_i & clk_en_i;
        irsprerr_o  = mrsprerr_i;
        irspdata_o  = mrspdata_i;
      end else begin
        drspvalid_o = mrspvalid_i & clk_en_i;
        mrspready_o = drspready_i & clk_en_i;
        drsprerr_o  = mrsprerr_i;
        drspwerr_o  = mrspwerr_i;
        drspdata_o  = mrspdata_i;
      end
    end
  end

endmodule
